// File: rtl/dt_pkg.sv
// Shared types for the table-driven decision-tree classifier.
//   node_w()  : width of one node word {leaf, fidx, thresh, left, right}
//   node_t    : node word layout for the default configuration
//               (N=8, NF=13, NODES=64)
//   state_t   : walk controller states
package dt_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_NF    = 13;
    localparam int DEF_NODES = 64;

    function automatic int node_w(input int n, input int nf, input int nodes);
        return 1 + $clog2(nf) + n + 2 * $clog2(nodes);
    endfunction

    localparam int DEF_NODE_W = node_w(DEF_N, DEF_NF, DEF_NODES);

    typedef struct packed {
        logic                          leaf;
        logic [$clog2(DEF_NF)-1:0]     fidx;
        logic [DEF_N-1:0]              thresh;
        logic [$clog2(DEF_NODES)-1:0]  left;
        logic [$clog2(DEF_NODES)-1:0]  right;
    } node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dt_node_mem.sv
// Node table: register file, synchronous write, asynchronous read, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : node word to store
//   raddr : read index
//   rdata : node word at raddr (combinational)
module dt_node_mem #(
    parameter int W     = 25,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents survive reset so a loaded tree outlives an aborted walk.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dt_tree_engine.sv
// Sequential decision-tree classifier. A sample is latched on accept and
// walked through the run-time loaded node table, one node per clock.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_we/addr/wdata, cfg_ready : node table write port (IDLE only)
//   in_valid/in_ready/in_features: sample input, feature f at [f*N +: N]
//   out_valid/out_ready           : result handshake
//   out_cls, out_err, out_depth   : class, abort flag, internal nodes visited
module dt_tree_engine
    import dt_pkg::*;
#(
    parameter int N         = 8,
    parameter int NF        = 13,
    parameter int C         = 1,
    parameter int NODES     = 64,
    parameter int MAX_DEPTH = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_we,
    input  logic [$clog2(NODES)-1:0]           cfg_addr,
    input  logic [node_w(N, NF, NODES)-1:0]    cfg_wdata,
    output logic                               cfg_ready,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NF*N-1:0]                    in_features,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [C-1:0]                       out_cls,
    output logic                               out_err,
    output logic [$clog2(MAX_DEPTH+1)-1:0]     out_depth
);

    localparam int FIDX_W = $clog2(NF);
    localparam int AW     = $clog2(NODES);
    localparam int NODE_W = node_w(N, NF, NODES);
    localparam int DW     = $clog2(MAX_DEPTH + 1);

    // One extra bit so an index equal to a power-of-two NF still compares correctly.
    localparam logic [FIDX_W:0] NF_L      = (FIDX_W + 1)'(NF);
    localparam logic [DW-1:0]   DEPTH_LIM = DW'(MAX_DEPTH);

    state_t              state_q, state_d;
    logic [NF*N-1:0]     feats;
    logic [AW-1:0]       cur;
    logic [DW-1:0]       depth;
    logic [NODE_W-1:0]   node_word;

    logic                nd_leaf;
    logic [FIDX_W-1:0]   nd_fidx;
    logic [N-1:0]        nd_thresh;
    logic [AW-1:0]       nd_left, nd_right;
    logic [FIDX_W-1:0]   fsel;
    logic [N-1:0]        feat_arr [NF];
    logic [N-1:0]        fval;
    logic                walk_bad, walk_end;

    dt_node_mem #(
        .W     (NODE_W),
        .DEPTH (NODES),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (cfg_we && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (cur),
        .rdata (node_word)
    );

    assign nd_right  = node_word[AW-1:0];
    assign nd_left   = node_word[2*AW-1:AW];
    assign nd_thresh = node_word[2*AW +: N];
    assign nd_fidx   = node_word[2*AW+N +: FIDX_W];
    assign nd_leaf   = node_word[NODE_W-1];

    for (genvar f = 0; f < NF; f++) begin : g_feat
        assign feat_arr[f] = feats[f*N +: N];
    end

    // An out-of-range index aborts the walk; steer the mux to a legal entry.
    assign walk_bad = !nd_leaf && (({1'b0, nd_fidx} >= NF_L) || (depth == DEPTH_LIM));
    assign walk_end = nd_leaf || walk_bad;
    assign fsel     = ({1'b0, nd_fidx} >= NF_L) ? '0 : nd_fidx;
    assign fval     = feat_arr[fsel];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = WALK;
            WALK:    if (walk_end)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        cfg_ready = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Sample latch: data only, never reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            feats <= in_features;
        end
    end

    // Walk pointer and result registers; results only change on a terminal
    // node, so they hold steady for the whole of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            depth     <= '0;
            out_cls   <= '0;
            out_err   <= 1'b0;
            out_depth <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cur   <= '0;
                        depth <= '0;
                    end
                end
                WALK: begin
                    if (nd_leaf) begin
                        out_cls   <= nd_thresh[C-1:0];
                        out_err   <= 1'b0;
                        out_depth <= depth;
                    end else if (walk_bad) begin
                        out_cls   <= '0;
                        out_err   <= 1'b1;
                        out_depth <= depth;
                    end else begin
                        // Strict unsigned less-than; true takes the left child.
                        cur   <= (fval < nd_thresh) ? nd_left : nd_right;
                        depth <= depth + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_tree_engine.sv
module tb_dt_tree_engine;
    import dt_pkg::*;

    localparam int N         = 8;
    localparam int NF        = 13;
    localparam int C         = 1;
    localparam int NODES     = 64;
    localparam int MAX_DEPTH = 15;
    localparam int FIDX_W    = $clog2(NF);
    localparam int AW        = $clog2(NODES);
    localparam int NODE_W    = node_w(N, NF, NODES);
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [NODE_W-1:0] cfg_wdata = '0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NF*N-1:0]   in_features = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [C-1:0]      out_cls;
    logic              out_err;
    logic [DW-1:0]     out_depth;

    int checks   = 0;
    int failures = 0;

    node_t mdl [NODES];

    dt_tree_engine #(
        .N(N), .NF(NF), .C(C), .NODES(NODES), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cls(out_cls), .out_err(out_err), .out_depth(out_depth)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic node_t mk(input logic leaf, input int fidx, input int thr, input int l, input int r);
        node_t n;
        n.leaf   = leaf;
        n.fidx   = FIDX_W'(fidx);
        n.thresh = N'(thr);
        n.left   = AW'(l);
        n.right  = AW'(r);
        return n;
    endfunction

    // Reference walk over the bench's copy of the table.
    function automatic void model(input logic [NF*N-1:0] f, output logic [C-1:0] cls,
                                  output logic err, output logic [DW-1:0] dep);
        node_t n;
        int cur = 0;
        int d   = 0;
        int fi;
        cls = '0; err = 1'b0;
        while (1) begin
            n  = mdl[cur];
            fi = int'(n.fidx);
            if (n.leaf) begin
                cls = n.thresh[C-1:0];
                break;
            end
            if (fi >= NF || d == MAX_DEPTH) begin
                err = 1'b1;
                break;
            end
            cur = (f[fi*N +: N] < n.thresh) ? int'(n.left) : int'(n.right);
            d++;
        end
        dep = DW'(d);
    endfunction

    task automatic cfg_write(input int addr, input node_t w);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = w;
        tick();
        cfg_we = 1'b0;
        mdl[addr] = w;
    endtask

    task automatic load_basic();
        cfg_write(0, mk(0, 2, 3, 1, 2));
        cfg_write(1, mk(1, 0, 0, 0, 0));
        cfg_write(2, mk(1, 0, 1, 0, 0));
    endtask

    function automatic logic [NF*N-1:0] rand_feats();
        logic [NF*N-1:0] v;
        for (int i = 0; i < NF; i++) v[i*N +: N] = N'($urandom);
        return v;
    endfunction

    // Offer one sample from IDLE, wait for the result (bounded), hold it for
    // 'hold' cycles, then complete the handshake. lat counts cycles from accept.
    task automatic run_sample(input logic [NF*N-1:0] f, input int hold, output logic [C-1:0] cls,
                              output logic err, output logic [DW-1:0] dep, output int lat);
        in_valid = 1'b1; in_features = f;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        cls = out_cls; err = out_err; dep = out_depth;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", cfg_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_cls !== '0) begin failures++; $display("FAIL reset_out_cls got=%0d exp=0", out_cls); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
        checks++; if (out_depth !== '0) begin failures++; $display("FAIL reset_out_depth got=%0d exp=0", out_depth); end
        for (int i = 0; i < NODES; i++) cfg_write(i, '0);
    endtask

    task automatic test_basic_tree();
        logic [NF*N-1:0] f;
        logic [C-1:0] cls; logic err; logic [DW-1:0] dep; int lat;
        int vals [4] = '{1, 3, 2, 255};
        int expc [4] = '{0, 1, 0, 1};
        load_basic();
        for (int k = 0; k < 4; k++) begin
            f = rand_feats();
            f[2*N +: N] = N'(vals[k]);
            run_sample(f, 0, cls, err, dep, lat);
            checks++; if (cls !== C'(expc[k])) begin failures++; $display("FAIL basic_cls feat2=%0d got=%0d exp=%0d", vals[k], cls, expc[k]); end
            checks++; if (err !== 1'b0 || dep !== DW'(1)) begin failures++; $display("FAIL basic_err_depth feat2=%0d got=%0b/%0d exp=0/1", vals[k], err, dep); end
            checks++; if (lat != 3) begin failures++; $display("FAIL basic_latency feat2=%0d got=%0d exp=3", vals[k], lat); end
        end
    endtask

    task automatic test_random();
        logic [NF*N-1:0] f;
        logic [C-1:0] cls, ecls; logic err, eerr; logic [DW-1:0] dep, edep; int lat;
        for (int i = 0; i < NODES; i++)
            cfg_write(i, mk($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 255),
                            $urandom_range(0, NODES - 1), $urandom_range(0, NODES - 1)));
        for (int s = 0; s < 30; s++) begin
            f = rand_feats();
            model(f, ecls, eerr, edep);
            run_sample(f, $urandom_range(0, 2), cls, err, dep, lat);
            checks++; if (cls !== ecls) begin failures++; $display("FAIL rand_cls s=%0d got=%0d exp=%0d", s, cls, ecls); end
            checks++; if (err !== eerr) begin failures++; $display("FAIL rand_err s=%0d got=%0b exp=%0b", s, err, eerr); end
            checks++; if (dep !== edep) begin failures++; $display("FAIL rand_depth s=%0d got=%0d exp=%0d", s, dep, edep); end
            checks++; if (lat != 2 + int'(edep)) begin failures++; $display("FAIL rand_latency s=%0d got=%0d exp=%0d", s, lat, 2 + int'(edep)); end
        end
    endtask

    task automatic test_back_pressure();
        logic [NF*N-1:0] f;
        int lat;
        load_basic();
        f = rand_feats();
        f[2*N +: N] = N'(9);
        in_valid = 1'b1; in_features = f;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin tick(); lat++; end
        checks++; if (lat != 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 5; c++) begin
            // A new offer while busy must be ignored.
            in_valid = 1'b1; in_features = '0;
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_handshake c=%0d got=%0b/%0b exp=1/0", c, out_valid, in_ready); end
            checks++; if ({out_cls, out_err, out_depth} !== {C'(1), 1'b0, DW'(1)}) begin failures++; $display("FAIL bp_hold_data c=%0d got=%0d/%0b/%0d exp=1/0/1", c, out_cls, out_err, out_depth); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b/%0b exp=0/1", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_extra got=%0b exp=0", out_valid); end
    endtask

    task automatic test_loop();
        logic [C-1:0] cls; logic err; logic [DW-1:0] dep; int lat;
        cfg_write(0, mk(0, 0, 0, 0, 0));
        run_sample(rand_feats(), 0, cls, err, dep, lat);
        checks++; if ({cls, err} !== {C'(0), 1'b1}) begin failures++; $display("FAIL loop_cls_err got=%0d/%0b exp=0/1", cls, err); end
        checks++; if (dep !== DW'(15)) begin failures++; $display("FAIL loop_depth got=%0d exp=15", dep); end
        checks++; if (lat != 17) begin failures++; $display("FAIL loop_latency got=%0d exp=17", lat); end
        cfg_write(0, mk(0, 3, 200, 0, 0));
        run_sample(rand_feats(), 1, cls, err, dep, lat);
        checks++; if ({cls, err, dep} !== {C'(0), 1'b1, DW'(15)} || lat != 17) begin failures++; $display("FAIL loop2 got=%0d/%0b/%0d lat=%0d exp=0/1/15 lat=17", cls, err, dep, lat); end
    endtask

    task automatic test_bad_fidx();
        logic [NF*N-1:0] f;
        logic [C-1:0] cls; logic err; logic [DW-1:0] dep; int lat;
        cfg_write(0, mk(0, 14, 7, 1, 2));
        run_sample(rand_feats(), 0, cls, err, dep, lat);
        checks++; if ({cls, err, dep} !== {C'(0), 1'b1, DW'(0)}) begin failures++; $display("FAIL fidx14 got=%0d/%0b/%0d exp=0/1/0", cls, err, dep); end
        checks++; if (lat != 2) begin failures++; $display("FAIL fidx14_latency got=%0d exp=2", lat); end
        // fidx == NF at depth 1, and fidx == NF-1 as the last legal index.
        cfg_write(0, mk(0, 0, 128, 1, 2));
        cfg_write(1, mk(0, 13, 0, 3, 3));
        cfg_write(2, mk(0, 12, 128, 3, 4));
        cfg_write(3, mk(1, 0, 1, 0, 0));
        cfg_write(4, mk(1, 0, 0, 0, 0));
        f = rand_feats(); f[0 +: N] = N'(5);
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if ({err, dep} !== {1'b1, DW'(1)} || lat != 3) begin failures++; $display("FAIL fidx13 got=%0b/%0d lat=%0d exp=1/1 lat=3", err, dep, lat); end
        f[0 +: N] = N'(200); f[12*N +: N] = N'(127);
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if ({cls, err, dep} !== {C'(1), 1'b0, DW'(2)}) begin failures++; $display("FAIL fidx12_left got=%0d/%0b/%0d exp=1/0/2", cls, err, dep); end
        f[12*N +: N] = N'(128);
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if ({cls, err, dep} !== {C'(0), 1'b0, DW'(2)}) begin failures++; $display("FAIL fidx12_right got=%0d/%0b/%0d exp=0/0/2", cls, err, dep); end
    endtask

    task automatic test_cfg_busy();
        logic [NF*N-1:0] f;
        logic [C-1:0] cls; logic err; logic [DW-1:0] dep; int lat;
        load_basic();
        f = rand_feats(); f[2*N +: N] = N'(1);
        in_valid = 1'b1; in_features = f;
        tick();
        in_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL busy_cfg_ready got=%0b exp=0", cfg_ready); end
        cfg_we = 1'b1; cfg_addr = AW'(1); cfg_wdata = mk(1, 0, 1, 0, 0);
        tick();
        cfg_we = 1'b0;
        lat = 2;
        while (!out_valid && lat < 64) begin tick(); lat++; end
        checks++; if (out_cls !== C'(0) || lat != 3) begin failures++; $display("FAIL busy_write_dropped got=%0d lat=%0d exp=0 lat=3", out_cls, lat); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if (cls !== C'(0)) begin failures++; $display("FAIL busy_table_unchanged got=%0d exp=0", cls); end
        cfg_write(1, mk(1, 0, 1, 0, 0));
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if (cls !== C'(1)) begin failures++; $display("FAIL idle_write_applied got=%0d exp=1", cls); end
        // A write in the accept cycle itself still lands.
        f[2*N +: N] = N'(50);
        in_valid = 1'b1; in_features = f;
        cfg_we = 1'b1; cfg_addr = AW'(2); cfg_wdata = mk(1, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0; cfg_we = 1'b0; mdl[2] = mk(1, 0, 0, 0, 0);
        lat = 1;
        while (!out_valid && lat < 64) begin tick(); lat++; end
        checks++; if (out_cls !== C'(0) || out_err !== 1'b0) begin failures++; $display("FAIL accept_cycle_write got=%0d/%0b exp=0/0", out_cls, out_err); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_midwalk();
        logic [NF*N-1:0] f;
        logic [C-1:0] cls; logic err; logic [DW-1:0] dep; int lat;
        load_basic();
        f = rand_feats(); f[2*N +: N] = N'(7);
        in_valid = 1'b1; in_features = f;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midwalk_reset got=%0b/%0b exp=0/1", out_valid, in_ready); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midwalk_discard got=%0b exp=0", out_valid); end
        run_sample(f, 0, cls, err, dep, lat);
        checks++; if ({cls, err, dep} !== {C'(1), 1'b0, DW'(1)} || lat != 3) begin failures++; $display("FAIL midwalk_table_kept got=%0d/%0b/%0d lat=%0d exp=1/0/1 lat=3", cls, err, dep, lat); end
    endtask

    initial begin
        test_reset();
        test_basic_tree();
        test_random();
        test_back_pressure();
        test_loop();
        test_bad_fidx();
        test_cfg_busy();
        test_reset_midwalk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
